// File: rtl/mips_io_port.sv
// mips_io_port: memory-mapped I/O peripheral on the MIPS data bus.
// Sits beside DataMemory and claims a 32-byte window at BASE_ADDR. It owns
// the PortIn/PortOut pins, synchronizes PortIn, and provides a countdown
// timer. Input-change and timer-done events are kept as sticky STATUS flags,
// and a registered, maskable interrupt line is driven from them.
//
// Bus semantics: MemRead and MemWrite are single-cycle strobes qualified by
// Address. There is no stall or ready signal, so every access completes in
// its own cycle. A load is combinational: ReadData is valid in the same cycle
// as MemRead and has no side effects. A store is committed at the rising edge
// that closes the cycle in which MemWrite is high. When both strobes are high
// in one cycle, ReadData shows the pre-edge register contents.
//
// Register map (byte offset within the window):
//   0x00 PORTOUT R/W
//   0x04 PORTIN  R    synchronized PortIn, zero-extended
//   0x08 STATUS  R/W1C bit0 IN_CHG, bit1 TMR_DONE
//   0x0C TIMER   R/W  countdown, stops at zero
//   0x10 CTRL    R/W  bit0 IE_CHG, bit1 IE_TMR
//   0x14..0x1C   read 0, writes ignored
//
// SYNC_STAGES must be at least 2. IN_WIDTH must be between 1 and 32.
module mips_io_port #(
  parameter int          IN_WIDTH    = 8,
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF0000,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemWrite,
  input  logic                MemRead,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         ReadData,
  output logic                IOSelect,
  output logic [31:0]         PortOut,
  output logic                IRQ
);

  // Word offsets (Address[4:2]) of the mapped registers.
  localparam logic [2:0] OFF_PORTOUT = 3'd0;
  localparam logic [2:0] OFF_PORTIN  = 3'd1;
  localparam logic [2:0] OFF_STATUS  = 3'd2;
  localparam logic [2:0] OFF_TIMER   = 3'd3;
  localparam logic [2:0] OFF_CTRL    = 3'd4;

  // Architectural state.
  logic [IN_WIDTH-1:0] r_sync [SYNC_STAGES];
  logic [IN_WIDTH-1:0] r_prev;
  logic [31:0]         r_portout;
  logic [31:0]         r_timer;
  logic [1:0]          r_status;
  logic [1:0]          r_ctrl;
  logic                r_irq;

  // Decode and next-state wires.
  logic                w_hit;
  logic [2:0]          w_offset;
  logic                w_wr;
  logic                w_wr_portout;
  logic                w_wr_status;
  logic                w_wr_timer;
  logic                w_wr_ctrl;
  logic [IN_WIDTH-1:0] w_sync;
  logic                w_in_chg_set;
  logic                w_tmr_done_set;
  logic [1:0]          w_w1c;
  logic [1:0]          w_status_next;
  logic [31:0]         w_portin_ext;
  logic [31:0]         w_rdata;
  logic                w_unused_addr;

  // Byte-lane bits are irrelevant for word-wide registers.
  assign w_unused_addr = ^Address[1:0];

  // Address decode. The hit is independent of the strobes, so the core's
  // read-back mux can be steered as soon as the address is known.
  always_comb begin
    w_hit        = (Address[31:5] == BASE_ADDR[31:5]);
    w_offset     = Address[4:2];
    w_wr         = w_hit && MemWrite;
    w_wr_portout = w_wr && (w_offset == OFF_PORTOUT);
    w_wr_status  = w_wr && (w_offset == OFF_STATUS);
    w_wr_timer   = w_wr && (w_offset == OFF_TIMER);
    w_wr_ctrl    = w_wr && (w_offset == OFF_CTRL);
  end

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Status flag events and the write-one-to-clear merge. A set event in the
  // same cycle as a clear of that bit wins, so no event is ever lost.
  always_comb begin
    w_in_chg_set   = (w_sync != r_prev);
    // The timer expires only on a real 1 -> 0 step; a load in that cycle
    // replaces the count and suppresses the flag.
    w_tmr_done_set = !w_wr_timer && (r_timer == 32'd1);
    w_w1c          = w_wr_status ? WriteData[1:0] : 2'b00;
    w_status_next  = (r_status & ~w_w1c) | {w_tmr_done_set, w_in_chg_set};
  end

  // PortIn synchronizer chain plus one more stage used for change detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= PortIn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
      r_prev <= w_sync;
    end
  end

  // Output port register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_portout <= 32'h0;
    end else if (w_wr_portout) begin
      r_portout <= WriteData;
    end
  end

  // Countdown timer: a load has priority, otherwise count down and hold at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timer <= 32'h0;
    end else if (w_wr_timer) begin
      r_timer <= WriteData;
    end else if (r_timer != 32'h0) begin
      r_timer <= r_timer - 32'd1;
    end
  end

  // Sticky status flags and the interrupt-enable register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_status <= 2'b00;
      r_ctrl   <= 2'b00;
    end else begin
      r_status <= w_status_next;
      if (w_wr_ctrl) begin
        r_ctrl <= WriteData[1:0];
      end
    end
  end

  // Interrupt is registered from the current flags, one cycle behind them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_status & r_ctrl);
    end
  end

  // Zero-extend the synchronized input to a bus word.
  always_comb begin
    w_portin_ext                = 32'h0;
    w_portin_ext[IN_WIDTH-1:0]  = w_sync;
  end

  // Combinational load data; zero unless this block is addressed and read.
  always_comb begin
    w_rdata = 32'h0;
    if (w_hit && MemRead) begin
      case (w_offset)
        OFF_PORTOUT: w_rdata = r_portout;
        OFF_PORTIN:  w_rdata = w_portin_ext;
        OFF_STATUS:  w_rdata = {30'h0, r_status};
        OFF_TIMER:   w_rdata = r_timer;
        OFF_CTRL:    w_rdata = {30'h0, r_ctrl};
        default:     w_rdata = 32'h0;
      endcase
    end
  end

  assign ReadData = w_rdata;
  assign IOSelect = w_hit;
  assign PortOut  = r_portout;
  assign IRQ      = r_irq;

endmodule

// File: tb/tb_mips_io_port.sv
// Directed testbench for mips_io_port: hand-computed expected values, every
// comparison routed through one check task, summary line at the end.
module tb_mips_io_port;

  localparam logic [31:0] A_PORTOUT = 32'hFFFF0000;
  localparam logic [31:0] A_PORTIN  = 32'hFFFF0004;
  localparam logic [31:0] A_STATUS  = 32'hFFFF0008;
  localparam logic [31:0] A_TIMER   = 32'hFFFF000C;
  localparam logic [31:0] A_CTRL    = 32'hFFFF0010;
  localparam logic [31:0] A_UNMAP   = 32'hFFFF0018;
  localparam logic [31:0] A_DMEM    = 32'h10010000;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemWrite;
  logic        MemRead;
  logic [7:0]  PortIn;
  logic [31:0] ReadData;
  logic        IOSelect;
  logic [31:0] PortOut;
  logic        IRQ;

  int n_checks;
  int n_errors;
  logic [31:0] exp_q[$];

  mips_io_port #(
    .IN_WIDTH   (8),
    .BASE_ADDR  (32'hFFFF0000),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemWrite (MemWrite),
    .MemRead  (MemRead),
    .PortIn   (PortIn),
    .ReadData (ReadData),
    .IOSelect (IOSelect),
    .PortOut  (PortOut),
    .IRQ      (IRQ)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    MemRead   = 1'b0;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    WriteData = 32'h0;
  endtask

  task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    Address = addr;
    MemRead = 1'b1;
    #1;
    check(tag, ReadData, exp);
    MemRead = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset     = 1'b0;
    Address   = 32'h0;
    WriteData = 32'h0;
    MemWrite  = 1'b0;
    MemRead   = 1'b0;
    PortIn    = 8'h00;

    // Reset state
    repeat (2) tick();
    check("rst_portout", PortOut, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    load_check("rst_status", A_STATUS, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // PORTOUT write/read and decode
    store(A_PORTOUT, 32'hDEADBEEF);
    check("portout_pin", PortOut, 32'hDEADBEEF);
    load_check("portout_rd", A_PORTOUT, 32'hDEADBEEF);
    check("iosel_hit", {31'h0, IOSelect}, 32'h1);
    load_check("dmem_rd", A_DMEM, 32'h0);
    check("iosel_miss", {31'h0, IOSelect}, 32'h0);
    store(A_DMEM, 32'h12345678);
    check("dmem_wr_no_effect", PortOut, 32'hDEADBEEF);

    // Input synchronizer and IN_CHG
    @(negedge clk);
    PortIn = 8'hA5;
    tick();
    load_check("portin_c1", A_PORTIN, 32'h0);
    tick();
    load_check("portin_c2", A_PORTIN, 32'h000000A5);
    load_check("chg_not_yet", A_STATUS, 32'h0);
    tick();
    load_check("chg_set", A_STATUS, 32'h1);
    store(A_STATUS, 32'h1);
    load_check("chg_w1c", A_STATUS, 32'h0);

    // W1C colliding with a new change: set wins
    @(negedge clk);
    PortIn = 8'h3C;
    repeat (3) tick();
    load_check("chg_set2", A_STATUS, 32'h1);
    @(negedge clk);
    PortIn = 8'hC3;
    repeat (2) tick();
    store(A_STATUS, 32'h1);
    load_check("chg_set_wins", A_STATUS, 32'h1);
    store(A_STATUS, 32'h1);
    load_check("chg_w1c2", A_STATUS, 32'h0);

    // Timer countdown with IE_TMR
    store(A_CTRL, 32'h2);
    load_check("ctrl_rd", A_CTRL, 32'h2);
    store(A_TIMER, 32'd3);
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd2);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    for (int i = 0; i < 4; i++) begin
      load_check($sformatf("timer_cnt%0d", i), A_TIMER, exp_q.pop_front());
      if (i < 3) load_check($sformatf("tmr_not_done%0d", i), A_STATUS, 32'h0);
      else       load_check("tmr_done", A_STATUS, 32'h2);
      check($sformatf("irq_cnt%0d", i), {31'h0, IRQ}, 32'h0);
      tick();
    end
    check("irq_tmr", {31'h0, IRQ}, 32'h1);
    load_check("timer_hold0", A_TIMER, 32'h0);
    store(A_STATUS, 32'h2);
    load_check("tmr_w1c", A_STATUS, 32'h0);
    tick();
    check("irq_cleared", {31'h0, IRQ}, 32'h0);
    store(A_TIMER, 32'h0);
    tick();
    load_check("load0_timer", A_TIMER, 32'h0);
    load_check("load0_no_done", A_STATUS, 32'h0);

    // Load collides with the 1 -> 0 step
    store(A_TIMER, 32'd1);
    store(A_TIMER, 32'd5);
    load_check("coll_timer", A_TIMER, 32'd5);
    load_check("coll_no_done", A_STATUS, 32'h0);
    store(A_TIMER, 32'h0);

    // Unmapped offset
    store(A_UNMAP, 32'hFFFFFFFF);
    load_check("unmap_rd", A_UNMAP, 32'h0);
    check("unmap_portout", PortOut, 32'hDEADBEEF);
    load_check("unmap_ctrl", A_CTRL, 32'h2);
    load_check("unmap_timer", A_TIMER, 32'h0);
    load_check("unmap_status", A_STATUS, 32'h0);

    // Masked interrupts: both flags set, CTRL=0
    store(A_CTRL, 32'h0);
    PortIn = 8'h11;
    store(A_TIMER, 32'd1);
    repeat (3) tick();
    load_check("both_flags", A_STATUS, 32'h3);
    repeat (2) tick();
    check("irq_masked", {31'h0, IRQ}, 32'h0);
    store(A_CTRL, 32'h3);
    check("irq_en_lag", {31'h0, IRQ}, 32'h0);
    tick();
    check("irq_en", {31'h0, IRQ}, 32'h1);

    // Asynchronous reset mid-run
    store(A_PORTOUT, 32'h55);
    check("pre_rst_portout", PortOut, 32'h55);
    #1;
    reset = 1'b0;
    #1;
    check("async_rst_portout", PortOut, 32'h0);
    check("async_rst_irq", {31'h0, IRQ}, 32'h0);
    load_check("async_rst_status", A_STATUS, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Simultaneous read and write of PORTOUT
    @(negedge clk);
    Address   = A_PORTOUT;
    WriteData = 32'h77;
    MemWrite  = 1'b1;
    MemRead   = 1'b1;
    #1;
    check("rw_pre_edge", ReadData, 32'h0);
    @(posedge clk);
    #1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    check("rw_portout", PortOut, 32'h77);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
